x_mem_responder: RTL and testbench



---
 rtl/x_mem_responder_pkg.sv | 24 ++
 rtl/x_mem_responder_bank.sv | 40 ++++
 rtl/x_mem_responder.sv | 145 ++++++++++++++
 tb/tb_x_mem_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/x_mem_responder_pkg.sv
// Shared definitions for the activation-memory responder: FSM states,
// bank indices and default widths.
package x_mem_responder_pkg;

  localparam int X_ADDR_LEN_DEF = 10;
  localparam int X_SEL_LEN_DEF  = 2;
  localparam int X_DEPTH_DEF    = 1024;
  localparam int X1_LEN_DEF     = 784;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum int {
    BANK_IN = 0,
    BANK_L1 = 1,
    BANK_L2 = 2,
    BANK_L3 = 3
  } bank_e;

endpackage

// File: rtl/x_mem_responder_bank.sv
// One 1-bit activation bank: single write port, registered engine and host
// read ports. Out-of-range addresses are dropped on write and read as 0.
module x_bank #(
  parameter int ADDR_LEN = 10,
  parameter int DEPTH    = 1024
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_LEN-1:0] waddr,
  input  logic                wdata,
  input  logic [ADDR_LEN-1:0] e_addr,
  output logic                e_data,
  input  logic [ADDR_LEN-1:0] h_addr,
  output logic                h_data
);

  localparam logic [ADDR_LEN:0] DEPTH_L = (ADDR_LEN + 1)'(DEPTH);

  logic mem [DEPTH];
  logic e_data_reg;
  logic h_data_reg;
  logic w_ok, e_ok, h_ok;

  assign w_ok = ({1'b0, waddr}  < DEPTH_L);
  assign e_ok = ({1'b0, e_addr} < DEPTH_L);
  assign h_ok = ({1'b0, h_addr} < DEPTH_L);

  // Reads sample the array before the write lands, giving read-before-write.
  always_ff @(posedge clk) begin
    if (we && w_ok) begin
      mem[waddr] <= wdata;
    end
    e_data_reg <= e_ok ? mem[e_addr] : 1'b0;
    h_data_reg <= h_ok ? mem[h_addr] : 1'b0;
  end

  assign e_data = e_data_reg;
  assign h_data = h_data_reg;

endmodule

// File: rtl/x_mem_responder.sv
// Activation-memory responder: loads the input image into bank 0, runs the
// engine with en, and serves engine and host accesses to four 1-bit banks.
module x_mem_responder
  import x_mem_responder_pkg::*;
#(
  parameter int X_ADDR_LEN = X_ADDR_LEN_DEF,
  parameter int X_DEPTH    = X_DEPTH_DEF,
  parameter int X_SEL_LEN  = X_SEL_LEN_DEF,
  parameter int X1_LEN     = X1_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  ld_valid,
  input  logic                  ld_data,
  output logic                  ld_ready,
  output logic                  en,
  input  logic                  compute_finish,
  input  logic [X_ADDR_LEN-1:0] x_addr,
  input  logic [X_SEL_LEN-1:0]  x_sel,
  input  logic                  x_wq,
  input  logic                  wx_write,
  output logic                  x_data,
  input  logic [X_ADDR_LEN-1:0] rd_addr,
  input  logic [X_SEL_LEN-1:0]  rd_sel,
  output logic                  rd_data,
  output logic                  busy,
  output logic                  done
);

  localparam int NBANK = 2 ** X_SEL_LEN;
  localparam logic [X_ADDR_LEN-1:0] LAST_IDX = X_ADDR_LEN'(X1_LEN - 1);

  state_t                state_reg, state_next;
  logic [X_ADDR_LEN-1:0] cnt_reg, cnt_next;
  logic                  en_reg;
  logic                  eng_ok_reg;
  logic                  host_ok_reg;
  logic [X_SEL_LEN-1:0]  e_sel_reg;
  logic [X_SEL_LEN-1:0]  h_sel_reg;

  logic                  load_we;
  logic                  eng_we;
  logic                  host_window;
  logic [X_ADDR_LEN-1:0] bank_waddr;
  logic                  bank_wdata;
  logic [NBANK-1:0]      bank_we;
  logic [NBANK-1:0]      bank_e_data;
  logic [NBANK-1:0]      bank_h_data;

  assign ld_ready    = (state_reg == ST_LOAD);
  assign load_we     = ld_ready && ld_valid;
  assign eng_we      = (state_reg == ST_RUN) && x_wq;
  assign host_window = (state_reg == ST_IDLE) || (state_reg == ST_DONE);

  // LOAD and RUN never overlap, so one shared write port per bank suffices.
  assign bank_waddr = load_we ? cnt_reg : x_addr;
  assign bank_wdata = load_we ? ld_data : wx_write;

  genvar gi;
  generate
    for (gi = 0; gi < NBANK; gi++) begin : g_bank
      if (gi == int'(BANK_IN)) begin : g_in
        assign bank_we[gi] = load_we || (eng_we && (x_sel == X_SEL_LEN'(gi)));
      end else begin : g_hidden
        assign bank_we[gi] = eng_we && (x_sel == X_SEL_LEN'(gi));
      end

      x_bank #(
        .ADDR_LEN (X_ADDR_LEN),
        .DEPTH    (X_DEPTH)
      ) u_bank (
        .clk    (clk),
        .we     (bank_we[gi]),
        .waddr  (bank_waddr),
        .wdata  (bank_wdata),
        .e_addr (x_addr),
        .e_data (bank_e_data[gi]),
        .h_addr (rd_addr),
        .h_data (bank_h_data[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_LOAD;
          cnt_next   = '0;
        end
      end
      ST_LOAD: begin
        if (load_we) begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == LAST_IDX) begin
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (compute_finish) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_next = ST_LOAD;
          cnt_next   = '0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      en_reg      <= 1'b0;
      eng_ok_reg  <= 1'b0;
      host_ok_reg <= 1'b0;
      e_sel_reg   <= '0;
      h_sel_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      // en lags RUN entry by a cycle but drops together with the finish edge.
      en_reg      <= (state_reg == ST_RUN) && !compute_finish;
      eng_ok_reg  <= (state_reg == ST_RUN);
      host_ok_reg <= host_window;
      e_sel_reg   <= x_sel;
      h_sel_reg   <= rd_sel;
    end
  end

  assign en      = en_reg;
  assign busy    = (state_reg == ST_LOAD) || (state_reg == ST_RUN);
  assign done    = (state_reg == ST_DONE);
  assign x_data  = eng_ok_reg && (state_reg == ST_RUN) && bank_e_data[e_sel_reg];
  assign rd_data = host_ok_reg && host_window && bank_h_data[h_sel_reg];

endmodule

// File: tb/tb_x_mem_responder.sv
// Directed + randomized bench for x_mem_responder against a flat array model
// of the four banks.
module tb_x_mem_responder;
  import x_mem_responder_pkg::*;

  localparam int AW    = 10;
  localparam int SW    = 2;
  localparam int DEPTH = 1000;
  localparam int NBITS = 784;

  logic          clk = 1'b0;
  logic          rst, start, ld_valid, ld_data, compute_finish;
  logic          x_wq, wx_write;
  logic [AW-1:0] x_addr, rd_addr;
  logic [SW-1:0] x_sel, rd_sel;
  logic          ld_ready, en, x_data, rd_data, busy, done;

  int n_vec = 0;
  int n_err = 0;

  bit model_mem [4][1024];
  bit known     [4][1024];

  x_mem_responder #(
    .X_ADDR_LEN (AW),
    .X_DEPTH    (DEPTH),
    .X_SEL_LEN  (SW),
    .X1_LEN     (NBITS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .ld_valid       (ld_valid),
    .ld_data        (ld_data),
    .ld_ready       (ld_ready),
    .en             (en),
    .compute_finish (compute_finish),
    .x_addr         (x_addr),
    .x_sel          (x_sel),
    .x_wq           (x_wq),
    .wx_write       (wx_write),
    .x_data         (x_data),
    .rd_addr        (rd_addr),
    .rd_sel         (rd_sel),
    .rd_data        (rd_data),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One engine cycle; expected read value is the model before this cycle's write.
  task automatic eng_op(input int sel, input int addr, input bit wq, input bit wd, input string tag);
    bit exp_v;
    bit chk;
    @(negedge clk);
    x_sel = SW'(sel); x_addr = AW'(addr); x_wq = wq; wx_write = wd;
    if (addr >= DEPTH) begin
      exp_v = 1'b0; chk = 1'b1;
    end else begin
      exp_v = model_mem[sel][addr]; chk = known[sel][addr];
      if (wq) begin
        model_mem[sel][addr] = wd; known[sel][addr] = 1'b1;
      end
    end
    @(posedge clk); #1;
    if (chk) check_bit(tag, x_data, exp_v);
  endtask

  task automatic host_rd(input int sel, input int addr, input bit in_window, input string tag);
    bit exp_v;
    bit chk;
    @(negedge clk);
    x_wq = 1'b0; rd_sel = SW'(sel); rd_addr = AW'(addr);
    if (!in_window || addr >= DEPTH) begin
      exp_v = 1'b0; chk = 1'b1;
    end else begin
      exp_v = model_mem[sel][addr]; chk = known[sel][addr];
    end
    @(posedge clk); #1;
    if (chk) check_bit(tag, rd_data, exp_v);
  endtask

  // mode: 0 always valid, 1 valid on odd cycles, 2 random; pat: 0 alternating 1/0, 1 random
  task automatic load_image(input int mode, input int pat, input int nbits,
                            input int exp_cycles, input string tag);
    int idx, cyc, it;
    bit v, b, hs;
    idx = 0; cyc = 0; it = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    check_bit({tag, "_entry_busy"}, busy, 1'b1);
    check_bit({tag, "_entry_ready"}, ld_ready, 1'b1);
    while (idx < nbits && it < 4000) begin
      @(negedge clk); start = 1'b0;
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
      b = (pat == 0) ? (idx % 2 == 0) : 1'($urandom_range(0, 1));
      ld_valid = v; ld_data = b; #1;
      hs = v && ld_ready;
      if (ld_ready) cyc++;
      it++;
      @(posedge clk);
      if (hs) begin
        model_mem[0][idx] = b; known[0][idx] = 1'b1; idx++;
      end
    end
    check_int({tag, "_bits"}, idx, nbits);
    if (exp_cycles >= 0) check_int({tag, "_ready_cycles"}, cyc, exp_cycles);
    if (nbits == NBITS) begin
      @(negedge clk); ld_valid = 1'b0; #1;
      check_bit({tag, "_ready_drop"}, ld_ready, 1'b0);
      check_bit({tag, "_en_wait"}, en, 1'b0);
      check_bit({tag, "_run_busy"}, busy, 1'b1);
      @(negedge clk); #1;
      check_bit({tag, "_en_rise"}, en, 1'b1);
    end
  endtask

  task automatic finish_run(input string tag);
    @(negedge clk); x_wq = 1'b0; compute_finish = 1'b1;
    @(posedge clk); #1;
    check_bit({tag, "_en_off"}, en, 1'b0);
    check_bit({tag, "_done"}, done, 1'b1);
    check_bit({tag, "_busy"}, busy, 1'b0);
    @(negedge clk); compute_finish = 1'b0; #1;
    check_bit({tag, "_xdata_zero"}, x_data, 1'b0);
  endtask

  task automatic random_ops(input int n);
    int r, sel, addr;
    for (int k = 0; k < n; k++) begin
      sel = $urandom_range(0, 3);
      r   = $urandom_range(0, 9);
      addr = (r < 7) ? $urandom_range(0, 31) : (r < 9) ? $urandom_range(990, 1023)
                                                       : $urandom_range(0, NBITS - 1);
      eng_op(sel, addr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand_eng");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_data = 1'b0; compute_finish = 1'b0;
    x_wq = 1'b0; wx_write = 1'b0; x_addr = '0; x_sel = '0; rd_addr = '0; rd_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    check_bit("rst_en", en, 1'b0);
    check_bit("rst_ld_ready", ld_ready, 1'b0);
    check_bit("rst_x_data", x_data, 1'b0);
    check_bit("rst_rd_data", rd_data, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    @(negedge clk); rst = 1'b0;

    // compute_finish in IDLE must be ignored
    @(negedge clk); compute_finish = 1'b1;
    @(posedge clk); #1;
    check_bit("idle_cf_busy", busy, 1'b0);
    check_bit("idle_cf_done", done, 1'b0);
    check_bit("idle_cf_en", en, 1'b0);
    @(negedge clk); compute_finish = 1'b0;
    host_rd(0, 1023, 1'b1, "idle_rd_oor");

    // Scenario 1: alternating image, ld_valid always high
    load_image(0, 0, NBITS, NBITS, "load1");
    eng_op(int'(BANK_L1), 5, 1'b1, 1'b1, "wr_l1_5");
    eng_op(int'(BANK_L1), 5, 1'b0, 1'b0, "rd_l1_5");
    eng_op(int'(BANK_L2), 7, 1'b1, 1'b0, "init_l2_7");
    eng_op(int'(BANK_L2), 7, 1'b1, 1'b1, "rbw_l2_7");
    eng_op(int'(BANK_L2), 7, 1'b0, 1'b0, "new_l2_7");
    for (int s = 0; s < 4; s++) begin
      eng_op(s, 1023, 1'b1, 1'b1, "oor_wr");
      eng_op(s, 1023, 1'b0, 1'b0, "oor_rd");
    end
    eng_op(int'(BANK_L3), 999, 1'b1, 1'b1, "wr_edge_999");
    eng_op(int'(BANK_L3), 999, 1'b0, 1'b0, "rd_edge_999");
    eng_op(int'(BANK_L3), 1000, 1'b0, 1'b0, "rd_oor_1000");
    eng_op(int'(BANK_IN), 0, 1'b0, 1'b0, "rd_in_0");
    host_rd(0, 0, 1'b0, "rd_gated_run");
    random_ops(200);
    finish_run("fin1");
    host_rd(0, 0, 1'b1, "rb1_in_0");
    host_rd(0, 1, 1'b1, "rb1_in_1");
    host_rd(0, 783, 1'b1, "rb1_in_783");
    host_rd(1, 5, 1'b1, "rb1_l1_5");
    host_rd(2, 7, 1'b1, "rb1_l2_7");
    host_rd(3, 999, 1'b1, "rb1_l3_999");
    for (int k = 0; k < 8; k++) host_rd(0, $urandom_range(0, NBITS - 1), 1'b1, "rb1_rand");

    // Scenario 2: restart from DONE, ld_valid low every other cycle
    load_image(1, 0, NBITS, 2 * NBITS, "load2");
    random_ops(50);
    finish_run("fin2");
    host_rd(0, 0, 1'b1, "rb2_in_0");
    host_rd(0, 1, 1'b1, "rb2_in_1");
    host_rd(0, 783, 1'b1, "rb2_in_783");
    for (int k = 0; k < 8; k++) host_rd($urandom_range(0, 3), $urandom_range(0, 40), 1'b1, "rb2_rand");

    // Scenario 3: random partial load abandoned by reset at counter 300
    load_image(2, 1, 300, -1, "load3");
    @(negedge clk); rst = 1'b1; ld_valid = 1'b0;
    @(posedge clk); #1;
    check_bit("rst_mid_ready", ld_ready, 1'b0);
    check_bit("rst_mid_busy", busy, 1'b0);
    check_bit("rst_mid_done", done, 1'b0);
    check_bit("rst_mid_en", en, 1'b0);
    @(negedge clk); rst = 1'b0;
    for (int a = 0; a < 300; a++) host_rd(0, a, 1'b1, "rb3_keep");
    for (int k = 0; k < 8; k++) host_rd(0, $urandom_range(300, NBITS - 1), 1'b1, "rb3_old");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
